// File: rtl/pwm_write_scheduler_pkg.sv
// Shared definitions for the PWM write scheduler: command word layout,
// clock-divider address and FSM state encoding.
package pwm_write_scheduler_pkg;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned ADDR_MSB = 15;
  localparam int unsigned ADDR_LSB = 12;
  localparam int unsigned DATA_MSB = 11;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [ADDR_W-1:0] CLKDIV_ADDR = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_DRAIN
  } state_t;

  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [CMD_W-1:0] w);
    return w[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/pwm_write_scheduler_if.sv
// Command-in / write-strobe-out bundle of the PWM write scheduler.
interface pwm_write_scheduler_if
  import pwm_write_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd_data;
  logic              period_tick;
  logic              sync_mode;
  logic              clr_flags;
  logic [DATA_W-1:0] wr_data;
  logic [NUM_CH-1:0] pwm_wr;
  logic              clk_div_wr;
  logic              busy;
  logic              overflow;
  logic              bad_addr;

  modport master (
    output cmd_valid, cmd_data, period_tick, sync_mode, clr_flags,
    input  cmd_ready, wr_data, pwm_wr, clk_div_wr, busy, overflow, bad_addr
  );

  modport slave (
    input  cmd_valid, cmd_data, period_tick, sync_mode, clr_flags,
    output cmd_ready, wr_data, pwm_wr, clk_div_wr, busy, overflow, bad_addr
  );
endinterface

// File: rtl/pwm_write_scheduler_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data and occupancy count.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end
endmodule

// File: rtl/pwm_write_scheduler.sv
// Buffers SPI command words and issues one-cycle write strobes to the PWM
// channels or the clock divider, optionally holding channel writes until a
// PWM period boundary.
module pwm_write_scheduler
  import pwm_write_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CLKDIV_ADDR = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_write_scheduler_if.slave  bus
);
  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] W_CLKDIV = ADDR_W'(CLKDIV_ADDR);

  state_t            r_state;
  logic [PTR_W:0]    r_drain_cnt;
  logic              r_iss_valid;
  logic [ADDR_W-1:0] r_iss_addr;
  logic [DATA_W-1:0] r_iss_data;
  logic [NUM_CH-1:0] r_pwm_wr;
  logic              r_clk_div_wr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_overflow;
  logic              r_bad_addr;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W:0]    w_count;
  logic [CMD_W-1:0]  w_head;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_is_ch;
  logic              w_iss_is_ch;
  logic [NUM_CH-1:0] w_iss_onehot;
  logic              w_bad_set;
  logic              w_ovf_set;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.cmd_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_push       = bus.cmd_valid && !w_full;
  assign w_ovf_set    = bus.cmd_valid && w_full;
  assign w_head_addr  = cmd_addr(w_head);
  assign w_head_is_ch = (32'(w_head_addr) < NUM_CH);
  assign w_iss_is_ch  = (32'(r_iss_addr) < NUM_CH);
  assign w_bad_set    = r_iss_valid && !w_iss_is_ch && (r_iss_addr != W_CLKDIV);

  assign bus.cmd_ready  = !w_full;
  assign bus.busy       = !w_empty || (r_state != ST_IDLE);
  assign bus.pwm_wr     = r_pwm_wr;
  assign bus.clk_div_wr = r_clk_div_wr;
  assign bus.wr_data    = r_wr_data;
  assign bus.overflow   = r_overflow;
  assign bus.bad_addr   = r_bad_addr;

  // Pop decision: IDLE pops anything not held for a tick; DRAIN pops every cycle.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE:  w_pop = !w_empty && !(w_head_is_ch && bus.sync_mode);
      ST_DRAIN: w_pop = !w_empty;
      default:  w_pop = 1'b0;
    endcase
  end

  // Scheduling FSM; DRAIN only pops the entries present when the tick arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && w_head_is_ch && bus.sync_mode) r_state <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!bus.sync_mode) begin
            r_state <= ST_IDLE;
          end else if (bus.period_tick) begin
            r_drain_cnt <= w_count;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - (PTR_W+1)'(1);
          if (r_drain_cnt <= (PTR_W+1)'(1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Issue stage: holds the popped entry for one cycle before strobing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_addr  <= '0;
      r_iss_data  <= '0;
    end else begin
      r_iss_valid <= w_pop;
      if (w_pop) begin
        r_iss_addr <= w_head_addr;
        r_iss_data <= w_head[DATA_LSB +: DATA_W];
      end
    end
  end

  // Channel index to one-hot strobe pattern.
  always_comb begin
    w_iss_onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(r_iss_addr) == i) w_iss_onehot[i] = 1'b1;
    end
  end

  // Registered one-cycle strobes; wr_data only changes with a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_wr     <= '0;
      r_clk_div_wr <= 1'b0;
      r_wr_data    <= '0;
    end else begin
      r_pwm_wr     <= '0;
      r_clk_div_wr <= 1'b0;
      if (r_iss_valid && w_iss_is_ch) begin
        r_pwm_wr  <= w_iss_onehot;
        r_wr_data <= r_iss_data;
      end else if (r_iss_valid && (r_iss_addr == W_CLKDIV)) begin
        r_clk_div_wr <= 1'b1;
        r_wr_data    <= r_iss_data;
      end
    end
  end

  // Sticky error flags; a set in the same cycle as clr_flags wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_bad_addr <= 1'b0;
    end else begin
      if (w_ovf_set)          r_overflow <= 1'b1;
      else if (bus.clr_flags) r_overflow <= 1'b0;
      if (w_bad_set)          r_bad_addr <= 1'b1;
      else if (bus.clr_flags) r_bad_addr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pwm_write_scheduler.sv
// Self-checking bench for pwm_write_scheduler: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_pwm_write_scheduler;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  pwm;
    logic        clkd;
    logic [11:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc_n;
  int   checks;
  int   errors;
  int   multi_hot;
  ev_t  events[$];

  pwm_write_scheduler_if #(.NUM_CH(8), .DATA_W(12)) bus ();

  pwm_write_scheduler #(
    .DEPTH(4), .NUM_CH(8), .DATA_W(12), .CLKDIV_ADDR(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n = cyc_n + 1;

  // Strobe monitor: records every strobe with the index of the edge that raised it.
  always @(negedge clk) begin
    if (bus.pwm_wr != 8'h00 || bus.clk_div_wr == 1'b1)
      events.push_back('{cyc: cyc_n, pwm: bus.pwm_wr, clkd: bus.clk_div_wr, data: bus.wr_data});
    if ($countones({bus.pwm_wr, bus.clk_div_wr}) > 1) multi_hot = multi_hot + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] w, output int acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    acc = cyc_n + 1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic tick(output int t);
    bus.period_tick = 1'b1;
    t = cyc_n + 1;
    step();
    bus.period_tick = 1'b0;
  endtask

  task automatic clear_flags();
    bus.clr_flags = 1'b1;
    step();
    bus.clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step();
    checks += 7;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.pwm_wr !== 8'h00) begin errors++; $display("FAIL reset_pwm_wr: got %h want 00", bus.pwm_wr); end
    if (bus.clk_div_wr !== 1'b0) begin errors++; $display("FAIL reset_clkdiv: got %b want 0", bus.clk_div_wr); end
    if (bus.wr_data !== 12'h000) begin errors++; $display("FAIL reset_wr_data: got %h want 000", bus.wr_data); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    if (bus.bad_addr !== 1'b0) begin errors++; $display("FAIL reset_bad_addr: got %b want 0", bus.bad_addr); end
  endtask

  task automatic test_single();
    ev_t exp[$];
    int  e;
    bus.sync_mode = 1'b0;
    events.delete();
    send(16'h3155, e);
    step(5);
    exp.push_back('{cyc: e + 2, pwm: 8'h08, clkd: 1'b0, data: 12'h155});
    checks++;
    if (events.size() != exp.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", events.size(), exp.size()); end
    foreach (exp[i]) if (i < events.size()) begin
      checks++;
      if (events[i] !== exp[i]) begin errors++;
        $display("FAIL single[%0d]: got cyc=%0d pwm=%h cd=%b d=%h want cyc=%0d pwm=%h cd=%b d=%h", i,
          events[i].cyc, events[i].pwm, events[i].clkd, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].clkd, exp[i].data); end
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    ev_t exp[$];
    int  e0, e1;
    bus.sync_mode = 1'b0;
    events.delete();
    send(16'h8007, e0);
    send(16'h0200, e1);
    step(5);
    exp.push_back('{cyc: e0 + 2, pwm: 8'h00, clkd: 1'b1, data: 12'h007});
    exp.push_back('{cyc: e1 + 2, pwm: 8'h01, clkd: 1'b0, data: 12'h200});
    checks++;
    if (events.size() != exp.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", events.size(), exp.size()); end
    foreach (exp[i]) if (i < events.size()) begin
      checks++;
      if (events[i] !== exp[i]) begin errors++;
        $display("FAIL b2b[%0d]: got cyc=%0d pwm=%h cd=%b d=%h want cyc=%0d pwm=%h cd=%b d=%h", i,
          events[i].cyc, events[i].pwm, events[i].clkd, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].clkd, exp[i].data); end
    end
  endtask

  task automatic test_sync_hold();
    ev_t exp[$];
    int  a, t, t2;
    bus.sync_mode = 1'b1;
    events.delete();
    send(16'h1010, a);
    send(16'h2020, a);
    step(10);
    checks += 2;
    if (events.size() != 0) begin errors++; $display("FAIL sync_hold_strobes: got %0d want 0", events.size()); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL sync_hold_busy: got %b want 1", bus.busy); end
    tick(t);
    send(16'h4040, a);
    step(8);
    exp.push_back('{cyc: t + 2, pwm: 8'h02, clkd: 1'b0, data: 12'h010});
    exp.push_back('{cyc: t + 3, pwm: 8'h04, clkd: 1'b0, data: 12'h020});
    checks++;
    if (events.size() != exp.size()) begin errors++; $display("FAIL sync_drain_count: got %0d want %0d", events.size(), exp.size()); end
    foreach (exp[i]) if (i < events.size()) begin
      checks++;
      if (events[i] !== exp[i]) begin errors++;
        $display("FAIL sync_drain[%0d]: got cyc=%0d pwm=%h cd=%b d=%h want cyc=%0d pwm=%h cd=%b d=%h", i,
          events[i].cyc, events[i].pwm, events[i].clkd, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].clkd, exp[i].data); end
    end
    checks += 2;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL sync_late_busy: got %b want 1", bus.busy); end
    if (bus.wr_data !== 12'h020) begin errors++; $display("FAIL sync_wr_data_hold: got %h want 020", bus.wr_data); end
    events.delete();
    exp.delete();
    tick(t2);
    step(8);
    exp.push_back('{cyc: t2 + 2, pwm: 8'h10, clkd: 1'b0, data: 12'h040});
    checks++;
    if (events.size() != exp.size()) begin errors++; $display("FAIL sync_next_tick_count: got %0d want %0d", events.size(), exp.size()); end
    foreach (exp[i]) if (i < events.size()) begin
      checks++;
      if (events[i] !== exp[i]) begin errors++;
        $display("FAIL sync_next_tick[%0d]: got cyc=%0d pwm=%h d=%h want cyc=%0d pwm=%h d=%h", i,
          events[i].cyc, events[i].pwm, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].data); end
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL sync_end_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_overflow();
    logic [15:0] words [5];
    ev_t exp[$];
    int  a, t;
    words = '{16'h0011, 16'h1022, 16'h2033, 16'h3044, 16'h4055};
    bus.sync_mode = 1'b1;
    events.delete();
    for (int i = 0; i < 4; i++) send(words[i], a);
    checks += 2;
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_full: got %b want 0", bus.cmd_ready); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
    send(words[4], a);
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
    clear_flags();
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    bus.clr_flags = 1'b1;
    send(16'h5066, a);
    bus.clr_flags = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clear: got %b want 1", bus.overflow); end
    clear_flags();
    tick(t);
    step(8);
    for (int i = 0; i < 4; i++)
      exp.push_back('{cyc: t + 2 + i, pwm: 8'(1) << i, clkd: 1'b0, data: words[i][11:0]});
    checks++;
    if (events.size() != exp.size()) begin errors++; $display("FAIL ovf_drain_count: got %0d want %0d", events.size(), exp.size()); end
    foreach (exp[i]) if (i < events.size()) begin
      checks++;
      if (events[i] !== exp[i]) begin errors++;
        $display("FAIL ovf_drain[%0d]: got cyc=%0d pwm=%h d=%h want cyc=%0d pwm=%h d=%h", i,
          events[i].cyc, events[i].pwm, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].data); end
    end
    checks += 2;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_after: got %b want 1", bus.cmd_ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_bad_addr();
    ev_t exp[$];
    int  e;
    bus.sync_mode = 1'b0;
    events.delete();
    send(16'hA123, e);
    step(4);
    checks += 2;
    if (events.size() != 0) begin errors++; $display("FAIL bad_no_strobe: got %0d strobes want 0", events.size()); end
    if (bus.bad_addr !== 1'b1) begin errors++; $display("FAIL bad_set: got %b want 1", bus.bad_addr); end
    send(16'h6066, e);
    step(4);
    exp.push_back('{cyc: e + 2, pwm: 8'h40, clkd: 1'b0, data: 12'h066});
    checks++;
    if (events.size() != exp.size()) begin errors++; $display("FAIL bad_next_count: got %0d want %0d", events.size(), exp.size()); end
    foreach (exp[i]) if (i < events.size()) begin
      checks++;
      if (events[i] !== exp[i]) begin errors++;
        $display("FAIL bad_next[%0d]: got cyc=%0d pwm=%h d=%h want cyc=%0d pwm=%h d=%h", i,
          events[i].cyc, events[i].pwm, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].data); end
    end
    clear_flags();
    checks++;
    if (bus.bad_addr !== 1'b0) begin errors++; $display("FAIL bad_clear: got %b want 0", bus.bad_addr); end
  endtask

  task automatic test_reset_mid_drain();
    int a, t, re, late;
    bus.sync_mode = 1'b1;
    events.delete();
    send(16'h0001, a);
    send(16'h1002, a);
    send(16'h2003, a);
    send(16'h3004, a);
    tick(t);
    step();
    rst = 1'b1;
    re  = cyc_n + 1;
    step();
    rst = 1'b0;
    checks += 4;
    if (bus.pwm_wr !== 8'h00) begin errors++; $display("FAIL rst_mid_pwm: got %h want 00", bus.pwm_wr); end
    if (bus.clk_div_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_clkdiv: got %b want 0", bus.clk_div_wr); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", bus.cmd_ready); end
    tick(t);
    step(10);
    late = 0;
    foreach (events[i]) if (int'(events[i].cyc) >= re) late++;
    checks++;
    if (late != 0) begin errors++; $display("FAIL rst_mid_late_strobes: got %0d want 0", late); end
  endtask

  task automatic test_random_nonsync();
    ev_t         exp[$];
    logic        bad_exp;
    logic        v;
    logic [3:0]  addr;
    logic [11:0] data;
    int          e;
    bus.sync_mode = 1'b0;
    clear_flags();
    events.delete();
    bad_exp = 1'b0;
    for (int n = 0; n < 300; n++) begin
      v    = ($urandom_range(0, 9) < 7);
      addr = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
      data = 12'($urandom);
      bus.cmd_valid = v;
      bus.cmd_data  = {addr, data};
      if (v) begin
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want 1", n, bus.cmd_ready); end
        e = cyc_n + 1;
        if (addr < 4'd8)       exp.push_back('{cyc: e + 2, pwm: 8'(1) << addr, clkd: 1'b0, data: data});
        else if (addr == 4'd8) exp.push_back('{cyc: e + 2, pwm: 8'h00, clkd: 1'b1, data: data});
        else                   bad_exp = 1'b1;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    step(6);
    checks++;
    if (events.size() != exp.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", events.size(), exp.size()); end
    foreach (exp[i]) if (i < events.size()) begin
      checks++;
      if (events[i] !== exp[i]) begin errors++;
        $display("FAIL rnd[%0d]: got cyc=%0d pwm=%h cd=%b d=%h want cyc=%0d pwm=%h cd=%b d=%h", i,
          events[i].cyc, events[i].pwm, events[i].clkd, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].clkd, exp[i].data); end
    end
    checks += 3;
    if (bus.bad_addr !== bad_exp) begin errors++; $display("FAIL rnd_bad_addr: got %b want %b", bus.bad_addr, bad_exp); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rnd_overflow: got %b want 0", bus.overflow); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_random_sync();
    ev_t         exp[$];
    logic [3:0]  addr;
    logic [11:0] data;
    int          n, a, t;
    bus.sync_mode = 1'b1;
    for (int r = 0; r < 15; r++) begin
      events.delete();
      exp.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        addr = (k == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 8));
        data = 12'($urandom);
        send({addr, data}, a);
        exp.push_back('{cyc: 0, pwm: (addr < 4'd8) ? 8'(1) << addr : 8'h00,
                        clkd: (addr == 4'd8), data: data});
      end
      step($urandom_range(1, 5));
      checks++;
      if (events.size() != 0) begin errors++; $display("FAIL rsync_pre_tick[%0d]: got %0d want 0", r, events.size()); end
      tick(t);
      step(8);
      foreach (exp[k]) exp[k].cyc = t + 2 + k;
      checks++;
      if (events.size() != exp.size()) begin errors++; $display("FAIL rsync_count[%0d]: got %0d want %0d", r, events.size(), exp.size()); end
      foreach (exp[i]) if (i < events.size()) begin
        checks++;
        if (events[i] !== exp[i]) begin errors++;
          $display("FAIL rsync[%0d][%0d]: got cyc=%0d pwm=%h cd=%b d=%h want cyc=%0d pwm=%h cd=%b d=%h", r, i,
            events[i].cyc, events[i].pwm, events[i].clkd, events[i].data, exp[i].cyc, exp[i].pwm, exp[i].clkd, exp[i].data); end
      end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsync_busy[%0d]: got %b want 0", r, bus.busy); end
    end
  endtask

  initial begin
    cyc_n = 0;
    checks = 0;
    errors = 0;
    multi_hot = 0;
    rst = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_data    = '0;
    bus.period_tick = 1'b0;
    bus.sync_mode   = 1'b0;
    bus.clr_flags   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_sync_hold();
    test_overflow();
    test_bad_addr();
    test_reset_mid_drain();
    test_random_nonsync();
    test_random_sync();
    checks++;
    if (multi_hot != 0) begin errors++; $display("FAIL one_hot: got %0d multi-strobe cycles want 0", multi_hot); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
